weight_mem_q14: RTL and testbench
=================================

Name: weight_mem_q14

Overview:
Q14 synaptic weight store: the responder for the STDP weight-write port (`w_we`/`w_addr`/`w_wdata`) and the read source for the inference datapath's weight fetch. It holds F*N signed 16-bit weights in a single-port array, one access per cycle. Writes are never back-pressured: they are clamped, buffered in a small write FIFO, and drained into the array when the read port is idle. Reads are coherent with pending buffered writes via FIFO bypass.

Parameters:
F, 48, presynaptic (input) count
N, 96, postsynaptic (neuron) count
WFIFO_DEPTH, 4, write-buffer entries (power of 2, >=2)
AW, $clog2((F*N)<=1?2:(F*N)), address width (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
w_we  in  1  write strobe from STDP; no ready, accepted unconditionally
w_addr  in  AW  write address (pre*N + post)
w_wdata  in  16  signed Q14 write data
wmin  in  16  signed clamp floor
wmax  in  16  signed clamp ceiling (wmin<=wmax guaranteed by software)
rd_req  in  1  read request
rd_addr  in  AW  read address
rd_ready  out  1  read accepted this cycle when rd_req&rd_ready
rd_valid  out  1  read data valid
rd_data  out  16  signed Q14 read data
init_done  out  1  array zero-sweep finished
wfifo_ovf  out  1  sticky: a write was dropped (FIFO full)
addr_err  out  1  sticky: out-of-range write or read address seen

Behaviour:
- Reset (rst=1 at posedge): state<=INIT, sweep ptr<=0, FIFO emptied, rd_valid<=0, rd_data<=0, init_done<=0, wfifo_ovf<=0, addr_err<=0. Reset mid-operation discards all FIFO contents and in-flight reads, then restarts the sweep.
- FSM INIT: writes 0 to addr ptr, ptr++ each cycle; at ptr==F*N-1, state<=RUN and init_done<=1 next cycle. Total F*N cycles. rd_ready=0 throughout.
- FSM RUN: per-cycle arbitration.
  - If rd_req&rd_ready: perform array read; the FIFO does not drain that cycle.
  - Else if FIFO non-empty: pop the oldest entry and write it to the array.
- rd_ready = (state==RUN) && (fifo_count < WFIFO_DEPTH). A full FIFO forces a drain cycle.
- Write accept (any state):
  - w_we=1 and w_addr<F*N: data clamped to [wmin,wmax] with a signed compare, then pushed.
  - w_addr>=F*N: dropped, addr_err<=1.
  - FIFO full and no pop that cycle: dropped, wfifo_ovf<=1. Only reachable in INIT.
  - Push and pop in the same cycle: count unchanged.
- Read latency is 1: request accepted in cycle t gives rd_valid=1 with rd_data in cycle t+1. rd_valid is a 1-cycle pulse per accepted read.
- Bypass: at accept time, rd_addr is compared to all valid FIFO entries. The newest matching entry's data is returned instead of the array data. A write presented in the same cycle as the read is NOT visible to that read; it is visible to reads in cycle t+1 onward.
- Out-of-range read: rd_data=0, rd_valid still pulses, addr_err<=1.
- Duplicate addresses in the FIFO: they drain in order, so the last write wins in the array.

Optional Feature:
WMEM_STATS_EN.
- Defined: adds outputs stat_wr_cnt[31:0] (accepted writes), stat_bypass_cnt[31:0] (reads served from FIFO) and stat_clamp_cnt[31:0] (writes altered by clamp). All three reset to 0, increment once per event, and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle: init_done rises exactly 4608 cycles after rst deasserts. Reading addr 0, 4607 and 100 returns 0 with rd_valid 1 cycle after accept.
- RUN, wmin=-16384, wmax=16384: write addr 5 with 20000 and addr 6 with -20000, then idle 4 cycles. Reads return 16384 and -16384; addr_err=0.
- FIFO bypass: hold rd_req every cycle on addr 9 while writing 123 then 456 to addr 9. The read in the cycle after the first write returns 123, the next returns 456. With rd_req continuous, rd_ready drops once count hits 4 and drains resume.
- Same-cycle hazard: array addr 7=10, then write 77 to addr 7 and read addr 7 in the same cycle. Returns 10; a read the next cycle returns 77.
- INIT overflow: 5 back-to-back writes during INIT with depth 4. The 5th is dropped, wfifo_ovf=1 stays set. After init, the first 4 values are readable and the 5th address reads 0.
- Out of range: write addr 4608 with value 1, then read 4700. addr_err=1, the read returns 0, and no in-range location changes.

Source files
------------

// File: rtl/weight_mem_q14_if.sv
// Weight-store bus: STDP write port, fetch read port and status.
// Stats signals exist only when WMEM_STATS_EN is defined.
interface weight_mem_q14_if #(
   parameter int AW = 13
);
   logic          w_we;
   logic [AW-1:0] w_addr;
   logic [15:0]   w_wdata;
   logic [15:0]   wmin;
   logic [15:0]   wmax;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ready;
   logic          rd_valid;
   logic [15:0]   rd_data;
   logic          init_done;
   logic          wfifo_ovf;
   logic          addr_err;
`ifdef WMEM_STATS_EN
   logic [31:0]   stat_wr_cnt;
   logic [31:0]   stat_bypass_cnt;
   logic [31:0]   stat_clamp_cnt;

   modport master (
      output w_we, w_addr, w_wdata, wmin, wmax,
      output rd_req, rd_addr,
      input  rd_ready, rd_valid, rd_data,
      input  init_done, wfifo_ovf, addr_err,
      input  stat_wr_cnt, stat_bypass_cnt, stat_clamp_cnt
   );
   modport slave (
      input  w_we, w_addr, w_wdata, wmin, wmax,
      input  rd_req, rd_addr,
      output rd_ready, rd_valid, rd_data,
      output init_done, wfifo_ovf, addr_err,
      output stat_wr_cnt, stat_bypass_cnt, stat_clamp_cnt
   );
`else
   modport master (
      output w_we, w_addr, w_wdata, wmin, wmax,
      output rd_req, rd_addr,
      input  rd_ready, rd_valid, rd_data,
      input  init_done, wfifo_ovf, addr_err
   );
   modport slave (
      input  w_we, w_addr, w_wdata, wmin, wmax,
      input  rd_req, rd_addr,
      output rd_ready, rd_valid, rd_data,
      output init_done, wfifo_ovf, addr_err
   );
`endif
endinterface

// File: rtl/weight_mem_q14.sv
// Q14 weight store: zero sweep, clamped write FIFO, bypassed reads.
// Optional WMEM_STATS_EN adds write/bypass/clamp event counters.
module weight_mem_q14 #(
   parameter  int F           = 48,
   parameter  int N           = 96,
   parameter  int WFIFO_DEPTH = 4,
   localparam int AW = $clog2((F*N) <= 1 ? 2 : (F*N))
) (
   input logic              clk,
   input logic              rst,
   weight_mem_q14_if.slave  bus
);
   localparam int DEPTH = F * N;
   localparam int PW    = $clog2(WFIFO_DEPTH);
   localparam int CW    = PW + 1;
   localparam logic [AW:0]   LIM  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(WFIFO_DEPTH);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_ptr;
   logic          r_init_done;
   logic [AW-1:0] r_fa [WFIFO_DEPTH];
   logic [15:0]   r_fd [WFIFO_DEPTH];
   logic [PW-1:0] r_rp;
   logic [PW-1:0] r_wp;
   logic [CW-1:0] r_cnt;
   logic          r_rd_valid;
   logic [15:0]   r_rd_data;
   logic          r_ovf;
   logic          r_addr_err;

   logic          w_run;
   logic          w_rd_ready;
   logic          w_rd_acc;
   logic          w_rd_ok;
   logic          w_wr_ok;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic [15:0]   w_clamped;
   logic          w_hit;
   logic [15:0]   w_hit_data;

   assign w_run      = (r_state == S_RUN);
   assign w_full     = (r_cnt == FULL);
   assign w_rd_ready = w_run && (r_cnt < FULL);
   assign w_rd_acc   = bus.rd_req && w_rd_ready;
   assign w_rd_ok    = ({1'b0, bus.rd_addr} < LIM);
   assign w_wr_ok    = ({1'b0, bus.w_addr} < LIM);
   // Idle read port lets the oldest buffered write reach the array.
   assign w_pop      = w_run && !w_rd_acc && (r_cnt != '0);
   assign w_push     = bus.w_we && w_wr_ok && (!w_full || w_pop);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_INIT;
      else     r_state <= w_state_nx;
   end

   // Next state: leave the sweep after the last address is zeroed.
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_INIT: if (r_ptr == LAST) w_state_nx = S_RUN;
         S_RUN:  w_state_nx = S_RUN;
      endcase
   end

   // Sweep pointer and completion flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_init_done <= 1'b0;
      end else if (r_state == S_INIT) begin
         if (r_ptr == LAST) r_init_done <= 1'b1;
         else               r_ptr       <= r_ptr + AW'(1);
      end
   end

   // Signed clamp of incoming write data.
   always_comb begin
      w_clamped = bus.w_wdata;
      if ($signed(bus.w_wdata) < $signed(bus.wmin))
         w_clamped = bus.wmin;
      else if ($signed(bus.w_wdata) > $signed(bus.wmax))
         w_clamped = bus.wmax;
   end

   // Bypass search, oldest to newest so the newest match wins.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_data = '0;
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
         if (CW'(i) < r_cnt &&
             r_fa[r_rp + PW'(i)] == bus.rd_addr) begin
            w_hit      = 1'b1;
            w_hit_data = r_fd[r_rp + PW'(i)];
         end
      end
   end

   // Single array port: sweep write, or drain write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == S_INIT) r_mem[r_ptr] <= '0;
         else if (w_pop)        r_mem[r_fa[r_rp]] <= r_fd[r_rp];
      end
   end

   // Read response, one cycle after accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            if (!w_rd_ok)   r_rd_data <= '0;
            else if (w_hit) r_rd_data <= w_hit_data;
            else            r_rd_data <= r_mem[bus.rd_addr];
         end
      end
   end

   // Write FIFO pointers, count and storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rp  <= '0;
         r_wp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fa[r_wp] <= bus.w_addr;
            r_fd[r_wp] <= w_clamped;
            r_wp       <= r_wp + PW'(1);
         end
         if (w_pop) r_rp <= r_rp + PW'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
      end
   end

   // Sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf      <= 1'b0;
         r_addr_err <= 1'b0;
      end else begin
         if (bus.w_we && w_wr_ok && w_full && !w_pop)
            r_ovf <= 1'b1;
         if ((bus.w_we && !w_wr_ok) || (w_rd_acc && !w_rd_ok))
            r_addr_err <= 1'b1;
      end
   end

   assign bus.rd_ready  = w_rd_ready;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.rd_data   = r_rd_data;
   assign bus.init_done = r_init_done;
   assign bus.wfifo_ovf = r_ovf;
   assign bus.addr_err  = r_addr_err;

`ifdef WMEM_STATS_EN
   logic [31:0] r_wr_cnt;
   logic [31:0] r_byp_cnt;
   logic [31:0] r_clmp_cnt;
   logic        w_clamp_chg;

   assign w_clamp_chg = (w_clamped != bus.w_wdata);

   // Event counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_cnt   <= '0;
         r_byp_cnt  <= '0;
         r_clmp_cnt <= '0;
      end else begin
         if (w_push) r_wr_cnt <= r_wr_cnt + 32'd1;
         if (w_rd_acc && w_rd_ok && w_hit)
            r_byp_cnt <= r_byp_cnt + 32'd1;
         if (w_push && w_clamp_chg)
            r_clmp_cnt <= r_clmp_cnt + 32'd1;
      end
   end

   assign bus.stat_wr_cnt     = r_wr_cnt;
   assign bus.stat_bypass_cnt = r_byp_cnt;
   assign bus.stat_clamp_cnt  = r_clmp_cnt;
`endif
endmodule

// File: tb/tb_weight_mem_q14.sv
// Bench for weight_mem_q14: flat-memory reference model and
// a read scoreboard drained by an independent monitor.
module tb_weight_mem_q14;
   localparam int F     = 48;
   localparam int N     = 96;
   localparam int AW    = 13;
   localparam int DEPTH = F * N;

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   int      cyc = 0;
   int      n_chk = 0;
   int      n_pass = 0;
   shortint ref_mem [DEPTH];
   exp_t    sb [$];
   shortint lo = -16384;
   shortint hi = 16384;
   int      init_cnt = 0;
   int      exp_wr = 0;
   logic    exp_ovf = 1'b0;
   logic    exp_aerr = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   weight_mem_q14_if #(.AW(AW)) bus ();

   weight_mem_q14 #(.F(F), .N(N), .WFIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // One cycle: drive at posedge+1, decide at negedge, update model.
   task automatic step(input logic we, input int wa,
                       input logic [15:0] wd, input logic rq,
                       input int ra, output logic acc);
      shortint v;
      bus.w_we    = we;
      bus.w_addr  = AW'(wa);
      bus.w_wdata = wd;
      bus.wmin    = lo;
      bus.wmax    = hi;
      bus.rd_req  = rq;
      bus.rd_addr = AW'(ra);
      @(negedge clk);
      acc = rq && bus.rd_ready;
      if (acc) begin
         if (ra < DEPTH) sb.push_back('{ref_mem[ra], cyc + 1});
         else begin
            sb.push_back('{16'h0, cyc + 1});
            exp_aerr = 1'b1;
         end
      end
      if (we) begin
         if (wa >= DEPTH) exp_aerr = 1'b1;
         else if (!bus.init_done && init_cnt >= 4) exp_ovf = 1'b1;
         else begin
            v = shortint'(wd);
            if (v < lo) v = lo;
            else if (v > hi) v = hi;
            ref_mem[wa] = v;
            exp_wr++;
            if (!bus.init_done) init_cnt++;
         end
      end
      @(posedge clk);
      #1;
      bus.w_we   = 1'b0;
      bus.rd_req = 1'b0;
   endtask

   task automatic idle(input int n);
      logic a;
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, a);
   endtask

   task automatic rd(input int addr);
      logic a;
      int   k;
      a = 1'b0;
      k = 0;
      while (!a && k < 20) begin
         step(0, 0, 16'h0, 1, addr, a);
         k++;
      end
      if (!a) begin
         n_chk++;
         $display("FAIL rd_accept: addr %0d not accepted", addr);
      end
   endtask

   // Monitor: every rd_valid pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.rd_valid) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL rd_valid: pulse with empty scoreboard");
            end else begin
               e = sb.pop_front();
               chk("rd_data", {16'h0, bus.rd_data}, {16'h0, e.d});
               chk("rd_latency", cyc, e.c);
            end
         end
      end
   end

   initial begin
      logic a;
      logic seen_nr;
      int   c0;
      int   k;
      shortint x;
      shortint y;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
      bus.w_we = 0; bus.w_addr = '0; bus.w_wdata = '0;
      bus.wmin = lo; bus.wmax = hi;
      bus.rd_req = 0; bus.rd_addr = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_init_done", {31'h0, bus.init_done}, 32'h0);
      chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk("rst_rd_data", {16'h0, bus.rd_data}, 32'h0);
      chk("rst_ovf", {31'h0, bus.wfifo_ovf}, 32'h0);
      chk("rst_addr_err", {31'h0, bus.addr_err}, 32'h0);
      chk("rst_rd_ready", {31'h0, bus.rd_ready}, 32'h0);
      c0  = cyc;
      rst = 1'b0;

      // Five writes during the sweep; the fifth overflows.
      for (int i = 0; i < 5; i++)
         step(1, 200 + i, 16'(1000 * (i + 1)), 1, 0, a);
      chk("init_rd_ready", {31'h0, a}, 32'h0);

      k = 0;
      while (!bus.init_done && k < 6000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("init_cycles", cyc - c0, DEPTH);
      chk("ovf_after_init", {31'h0, bus.wfifo_ovf}, {31'h0, exp_ovf});

      rd(0); rd(4607); rd(100);
      for (int i = 0; i < 5; i++) rd(200 + i);

      // Clamp.
      step(1, 5, 16'd20000, 0, 0, a);
      step(1, 6, -16'sd20000, 0, 0, a);
      idle(4);
      rd(5); rd(6);
      chk("clamp_addr_err", {31'h0, bus.addr_err}, 32'h0);

      // Bypass with continuous reads, then back-pressure.
      step(1, 9, 16'd123, 1, 9, a);
      step(1, 9, 16'd456, 1, 9, a);
      seen_nr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1, 10 + i, 16'(i), 1, 9, a);
         if (!a) seen_nr = 1'b1;
      end
      chk("rd_ready_drop", {31'h0, seen_nr}, 32'h1);
      idle(6);
      rd(9);

      // Same-cycle write/read hazard.
      step(1, 7, 16'd10, 0, 0, a);
      idle(6);
      step(1, 7, 16'd77, 1, 7, a);
      rd(7);

      // Randomized traffic over a small hot window.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(3) == 0) begin
            lo = -32768;
            hi = 32767;
         end else begin
            x = shortint'($urandom);
            y = shortint'($urandom);
            lo = (x < y) ? x : y;
            hi = (x < y) ? y : x;
         end
         step($urandom_range(1) == 1,
              ($urandom_range(7) == 0) ? $urandom_range(DEPTH - 1)
                                       : $urandom_range(15),
              16'($urandom),
              $urandom_range(2) != 0,
              $urandom_range(15), a);
      end
      lo = -16384;
      hi = 16384;
      idle(6);
      chk("rand_addr_err", {31'h0, bus.addr_err}, 32'h0);

      // Out-of-range write and read.
      step(1, 4608, 16'd1, 0, 0, a);
      rd(4700);
      idle(6);
      chk("oor_addr_err", {31'h0, bus.addr_err}, {31'h0, exp_aerr});
      rd(512); rd(0); rd(4607);
      for (int i = 0; i < 16; i++) rd(i);

`ifdef WMEM_STATS_EN
      chk("stat_wr_cnt", bus.stat_wr_cnt, exp_wr);
`endif
      idle(3);
      chk("sb_empty", sb.size(), 0);
      chk("ovf_sticky", {31'h0, bus.wfifo_ovf}, 32'h1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
